// File: rtl/uart_protocol_host.sv
// Host side of an ASCII-hex register protocol over a byte UART: issues
// write/read/reset streams, decodes 4-digit read replies, and skips re-sending sequential addresses.
module uart_protocol_host #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [1:0]  i_cmd,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdat,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_rdat,
    input  logic        i_uart_send_ready,
    output logic        o_uart_send_pulse,
    output logic [7:0]  o_uart_dat,
    input  logic        i_uart_received_pulse,
    input  logic [7:0]  i_uart_dat
);

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_RESET = 2'd2;

    localparam logic [7:0] CH_L    = 8'h4c;
    localparam logic [7:0] CH_W    = 8'h57;
    localparam logic [7:0] CH_R    = 8'h52;
    localparam logic [7:0] CH_STAR = 8'h2a;

    typedef enum logic [2:0] {
        IDLE, SEND_L, SEND_ADDR, SEND_OP, SEND_DATA, SEND_STAR, RECV
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    cmd, cmd_nxt;
    logic [15:0]   addr, addr_nxt;
    logic [15:0]   wdat, wdat_nxt;
    logic [1:0]    nib, nib_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [11:0]   shift, shift_nxt;
    logic [15:0]   rdat, rdat_nxt;
    logic [15:0]   cache_addr, cache_addr_nxt;
    logic          cache_valid, cache_valid_nxt;
    logic          busy, busy_nxt;
    logic          done, done_nxt;
    logic          err, err_nxt;
    logic          complete, fail;
    logic [4:0]    rx_dec;

    function automatic logic [7:0] hex_encode(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // {valid, value}; only lowercase hex digits are legal
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
        if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        return 5'd0;
    endfunction

    function automatic logic [3:0] nib_sel(input logic [15:0] w, input logic [1:0] n);
        case (n)
            2'd0:    return w[15:12];
            2'd1:    return w[11:8];
            2'd2:    return w[7:4];
            default: return w[3:0];
        endcase
    endfunction

    assign rx_dec = hex_decode(i_uart_dat);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            cmd         <= 2'd0;
            addr        <= 16'h0000;
            wdat        <= 16'h0000;
            nib         <= 2'd0;
            timer       <= '0;
            shift       <= 12'h000;
            rdat        <= 16'h0000;
            cache_addr  <= 16'h0000;
            cache_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd         <= cmd_nxt;
            addr        <= addr_nxt;
            wdat        <= wdat_nxt;
            nib         <= nib_nxt;
            timer       <= timer_nxt;
            shift       <= shift_nxt;
            rdat        <= rdat_nxt;
            cache_addr  <= cache_addr_nxt;
            cache_valid <= cache_valid_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        cmd_nxt           = cmd;
        addr_nxt          = addr;
        wdat_nxt          = wdat;
        nib_nxt           = nib;
        timer_nxt         = timer;
        shift_nxt         = shift;
        rdat_nxt          = rdat;
        cache_addr_nxt    = cache_addr;
        cache_valid_nxt   = cache_valid;
        done_nxt          = 1'b0;
        err_nxt           = 1'b0;
        complete          = 1'b0;
        fail              = 1'b0;
        o_uart_send_pulse = 1'b0;
        o_uart_dat        = 8'h00;

        case (state)
            IDLE: begin
                if (i_req) begin
                    cmd_nxt  = i_cmd;
                    addr_nxt = i_addr;
                    wdat_nxt = i_wdat;
                    case (i_cmd)
                        CMD_READ, CMD_WRITE:
                            state_nxt = (cache_valid && i_addr == cache_addr) ? SEND_OP : SEND_L;
                        CMD_RESET:
                            state_nxt = SEND_STAR;
                        default: begin
                            done_nxt        = 1'b1;
                            err_nxt         = 1'b1;
                            cache_valid_nxt = 1'b0;
                        end
                    endcase
                end
            end
            SEND_L: begin
                o_uart_dat = CH_L;
                if (i_uart_send_ready) begin
                    o_uart_send_pulse = 1'b1;
                    nib_nxt           = 2'd0;
                    state_nxt         = SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                o_uart_dat = hex_encode(nib_sel(addr, nib));
                if (i_uart_send_ready) begin
                    o_uart_send_pulse = 1'b1;
                    nib_nxt           = nib + 2'd1;
                    if (nib == 2'd3) state_nxt = SEND_OP;
                end
            end
            SEND_OP: begin
                o_uart_dat = (cmd == CMD_WRITE) ? CH_W : CH_R;
                if (i_uart_send_ready) begin
                    o_uart_send_pulse = 1'b1;
                    nib_nxt           = 2'd0;
                    timer_nxt         = '0;
                    state_nxt         = (cmd == CMD_WRITE) ? SEND_DATA : RECV;
                end
            end
            SEND_DATA: begin
                o_uart_dat = hex_encode(nib_sel(wdat, nib));
                if (i_uart_send_ready) begin
                    o_uart_send_pulse = 1'b1;
                    nib_nxt           = nib + 2'd1;
                    if (nib == 2'd3) complete = 1'b1;
                end
            end
            SEND_STAR: begin
                o_uart_dat = CH_STAR;
                if (i_uart_send_ready) begin
                    o_uart_send_pulse = 1'b1;
                    done_nxt          = 1'b1;
                    cache_valid_nxt   = 1'b0;
                    state_nxt         = IDLE;
                end
            end
            RECV: begin
                // A received byte takes priority over a coincident timeout
                if (i_uart_received_pulse) begin
                    if (rx_dec[4]) begin
                        shift_nxt = {shift[7:0], rx_dec[3:0]};
                        nib_nxt   = nib + 2'd1;
                        timer_nxt = '0;
                        if (nib == 2'd3) begin
                            rdat_nxt = {shift, rx_dec[3:0]};
                            complete = 1'b1;
                        end
                    end else begin
                        fail = 1'b1;
                    end
                end else if (timer == TLAST) begin
                    fail = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (complete) begin
            state_nxt       = IDLE;
            done_nxt        = 1'b1;
            cache_addr_nxt  = addr + 16'd1;
            cache_valid_nxt = 1'b1;
        end
        if (fail) begin
            state_nxt       = IDLE;
            done_nxt        = 1'b1;
            err_nxt         = 1'b1;
            cache_valid_nxt = 1'b0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    assign o_busy = busy;
    assign o_done = done;
    assign o_err  = err;
    assign o_rdat = rdat;

endmodule
